conv_ctrl_fsm: RTL and testbench

//  Parametrised control FSM for the sliding-window convolution datapath. Sequences raster

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_pix_counter.sv | 42 ++++
 rtl/conv_ctrl_fsm.sv | 139 +++++++++++++
 tb/tb_conv_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the sliding-window convolution control path.
package conv_pkg;

  // Controller state encoding; values are fixed so datapath and bench can decode them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    CAL   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/conv_pix_counter.sv
// Raster row/column counter: col wraps at IMG_W-1 into the next row, row wraps at frame end.
module conv_pix_counter #(
  parameter  int IMG_W = 64,
  parameter  int IMG_H = 64,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  // Advance one raster position per increment; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

endmodule

// File: rtl/conv_ctrl_fsm.sv
// Control FSM for the sliding-window convolution: pixel push, MAC enable, result handshake.
module conv_ctrl_fsm
  import conv_pkg::*;
#(
  parameter  int IMG_W   = 64,
  parameter  int IMG_H   = 64,
  parameter  int K       = 3,
  parameter  int MAC_LAT = 2,
  localparam int CW      = $clog2(IMG_W),
  localparam int RW      = $clog2(IMG_H),
  localparam int LW      = $clog2(MAC_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          pix_valid,
  output logic          pushpixel,
  output logic          multi_act,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          fin
);

  state_e        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          trig_last_q, trig_last_d;
  logic          multi_act_q, out_valid_q, busy_q, fin_q;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last;
  logic          cnt_clr, cnt_inc;
  logic          win_ok;

  conv_pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pix_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  // Pixel acceptance is the only output not taken from a register.
  assign pushpixel = (state_q == PUSH) && pix_valid;

  // Signed compare keeps the K=1 case from degenerating into an unsigned >= 0 test.
  assign win_ok = (int'(row) >= K - 1) && (int'(col) >= K - 1);

  // Next-state, counter control and window-origin capture; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    trig_last_d = trig_last_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PUSH;
          cnt_clr = 1'b1;
        end
      end
      PUSH: begin
        if (pix_valid) begin
          cnt_inc = 1'b1;
          if (win_ok) begin
            out_row_d   = row - RW'(K - 1);
            out_col_d   = col - CW'(K - 1);
            lat_d       = '0;
            trig_last_d = last;
            state_d     = CAL;
          end
        end
      end
      CAL: begin
        if (lat_q == LW'(MAC_LAT - 1)) state_d = WRITE;
        else                           lat_d   = lat_q + LW'(1);
      end
      WRITE: begin
        if (out_ready) state_d = trig_last_q ? DONE : PUSH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      cnt_clr     = 1'b1;
      cnt_inc     = 1'b0;
      lat_d       = '0;
      trig_last_d = 1'b0;
    end
  end

  // State and Moore outputs registered together; outputs decode the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      trig_last_q <= 1'b0;
      multi_act_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      trig_last_q <= trig_last_d;
      multi_act_q <= (state_d == CAL);
      out_valid_q <= (state_d == WRITE);
      busy_q      <= (state_d != IDLE);
      fin_q       <= (state_d == DONE);
    end
  end

  assign multi_act = multi_act_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign fin       = fin_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv_ctrl_fsm.sv
// Directed bench for conv_ctrl_fsm: 4x4 frame with K=3/MAC_LAT=2 and K=1/MAC_LAT=1.
module tb_conv_ctrl_fsm;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n, start, abort, pix_valid, out_ready;

  logic       push_a, mac_a, ov_a, busy_a, fin_a;
  logic [1:0] row_a, col_a;
  logic       push_b, mac_b, ov_b, busy_b, fin_b;
  logic [1:0] row_b, col_b;

  logic       sel;
  logic       m_push, m_mac, m_ov, m_busy, m_fin;
  logic [1:0] m_row, m_col;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  conv_ctrl_fsm #(.IMG_W(W), .IMG_H(H), .K(3), .MAC_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pix_valid(pix_valid),
    .pushpixel(push_a), .multi_act(mac_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_row(row_a), .out_col(col_a), .busy(busy_a), .fin(fin_a)
  );

  conv_ctrl_fsm #(.IMG_W(W), .IMG_H(H), .K(1), .MAC_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pix_valid(pix_valid),
    .pushpixel(push_b), .multi_act(mac_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_row(row_b), .out_col(col_b), .busy(busy_b), .fin(fin_b)
  );

  assign m_push = sel ? push_b : push_a;
  assign m_mac  = sel ? mac_b  : mac_a;
  assign m_ov   = sel ? ov_b   : ov_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_fin  = sel ? fin_b  : fin_a;
  assign m_row  = sel ? row_b  : row_a;
  assign m_col  = sel ? col_b  : col_a;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one frame on the selected DUT, scoreboarding results against raster-order windows.
  task automatic run_frame(input logic s, input int gap_at, input int stall_idx, input logic start_glitch);
    int kk, macl, pushes, results, fins, mac_cnt, hs_cyc, held, gap_left, e;
    logic gap_done, prev_ov, done;
    sel = s;
    kk   = s ? 1 : 3;
    macl = s ? 1 : 2;
    exp_q.delete();
    for (int r = 0; r <= H - kk; r++)
      for (int c = 0; c <= W - kk; c++)
        exp_q.push_back(r * 100 + c);
    pushes = 0; results = 0; fins = 0; mac_cnt = 0; hs_cyc = -10; held = 0; gap_left = 0;
    gap_done = 1'b0; prev_ov = 1'b0; done = 1'b0; e = 0;
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (fins > 0 && !m_fin) begin
        chk("idle_after_fin", m_busy, 0);
        done = 1'b1;
      end else begin
        if (m_push) pushes++;
        if (!pix_valid) chk("no_push_pv_low", m_push, 0);
        if (m_mac) begin
          mac_cnt++;
          chk("cal_no_push", m_push, 0);
        end
        if (m_ov) begin
          chk("write_no_push", m_push, 0);
          chk("write_no_mac", m_mac, 0);
          if (!prev_ov) begin
            chk("mac_len", mac_cnt, macl);
            mac_cnt = 0;
            if (exp_q.size() == 0) chk("extra_result", 1, 0);
            else e = exp_q.pop_front();
          end
          chk("out_row", int'(m_row), e / 100);
          chk("out_col", int'(m_col), e % 100);
        end
        if (m_fin) begin
          fins++;
          chk("fin_after_hs", cyc, hs_cyc + 1);
        end
        if (pushes == gap_at && !gap_done) begin
          gap_left = 3;
          gap_done = 1'b1;
        end
        if (gap_left > 0) begin
          pix_valid = 1'b0;
          gap_left--;
        end else begin
          pix_valid = 1'b1;
        end
        start = start_glitch && (cyc >= 4) && (cyc <= 6);
        if (m_ov && results == stall_idx && held < 5) begin
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = 1'b1;
        end
        if (m_ov && out_ready) begin
          results++;
          hs_cyc = cyc;
        end
        prev_ov = m_ov;
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("pushes", pushes, W * H);
    chk("results", results, (H - kk + 1) * (W - kk + 1));
    chk("fin_count", fins, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    if (stall_idx >= 0) chk("stall_cycles", held, 5);
  endtask

  // Drives dut_a until it enters CAL for its second result.
  task automatic to_second_cal(output logic reached);
    int seen_ov;
    seen_ov = 0;
    reached = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (m_ov) seen_ov = 1;
      if (m_mac && seen_ov == 1) reached = 1'b1;
      else @(negedge clk);
    end
    chk("reach_second_cal", int'(reached), 1);
  endtask

  initial begin
    logic reached;
    sel = 1'b0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_fin", fin_a, 0);
    do_reset();

    // Reset asserted mid-CAL of result (0,1): outputs drop without waiting for a clock edge.
    to_second_cal(reached);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_mac", mac_a, 0);
    chk("midrst_push", push_a, 0);
    chk("midrst_ov", ov_a, 0);
    chk("midrst_fin", fin_a, 0);
    chk("midrst_row", int'(row_a), 0);
    chk("midrst_col", int'(col_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame, continuous valid/ready.
    run_frame(1'b0, -1, -1, 1'b0);
    // Upstream gap of 3 cycles after 2 pushes, plus start pulsed mid-frame.
    run_frame(1'b0, 2, -1, 1'b1);
    // Writer holds off the second result for 5 cycles.
    run_frame(1'b0, -1, 1, 1'b0);

    // Abort during CAL of the second result.
    to_second_cal(reached);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_mac", mac_a, 0);
    chk("abort_ov", ov_a, 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_fin", fin_a, 0);
      @(negedge clk);
    end
    // start and abort together in IDLE keep the FSM idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy_a, 0);
    // Recovery after abort.
    run_frame(1'b0, -1, -1, 1'b0);

    // K=1, MAC_LAT=1 instance: one result per pixel.
    do_reset();
    run_frame(1'b1, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
